// File: rtl/vga_fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_pkg
//  Description : Shared constants for the framebuffer scanout path.
//                Framebuffer geometry, pixel word width, the first
//                non-visible row shared with the VGA timing generator, and
//                the state encoding of the scanout arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package vga_fb_pkg;

    localparam int FB_ADDR_W = 16;      // framebuffer address width
    localparam int DATA_W    = 8;       // pixel word width
    localparam int FB_SIZE   = 23040;   // 160x144 pixels, linear scan order
    localparam int V_VISIBLE = 480;     // first non-visible row (frame restart)

    typedef enum logic [0:0] {
        sRUN   = 1'b0,
        sFLUSH = 1'b1
    } fb_state_t;

endpackage : vga_fb_pkg
`default_nettype wire

// File: rtl/vga_pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_fifo
//  Description : Synchronous FIFO with a registered head output.
//                clear has priority over push and pop. Pop on an empty FIFO
//                and push on a full FIFO (without a pop) are ignored.
//  Ports       : clk, rst_n        clock, async active-low reset
//                clear             drop all entries
//                push, push_data   write one entry
//                pop               remove the head entry
//                data              head entry (0 when empty)
//                count             number of stored entries
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_pop_eff;
    logic             w_push_eff;
    logic [PTR_W-1:0] w_rptr_next;
    logic [CNT_W-1:0] w_count_after_pop;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] w_head_next;

    assign w_pop_eff  = pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_eff = push && ((r_count != c_depth) || w_pop_eff);

    always_comb begin
        w_rptr_next       = r_rptr + PTR_W'(w_pop_eff);
        w_count_after_pop = r_count - CNT_W'(w_pop_eff);
        w_count_next      = w_count_after_pop + CNT_W'(w_push_eff);
        // Head register: empty -> 0; the incoming word becomes head when
        // nothing older remains; otherwise the next stored entry.
        if (w_count_next == '0) begin
            w_head_next = '0;
        end else if (w_count_after_pop == '0) begin
            w_head_next = push_data;
        end else begin
            w_head_next = r_mem[w_rptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_eff && !clear) begin
            r_mem[r_wptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_head  <= '0;
        end else begin
            r_wptr  <= r_wptr + PTR_W'(w_push_eff);
            r_rptr  <= w_rptr_next;
            r_count <= w_count_next;
            r_head  <= w_head_next;
        end
    end

    assign data  = r_head;
    assign count = r_count;

endmodule : vga_pixel_fifo
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_fb_arbiter
//  Description : Shares a single-port framebuffer RAM between display
//                scanout (prefetch into a small FIFO) and a pixel writer.
//                Urgent reads beat writes, writes beat background reads.
//                Scanout restarts from address 0 at the first non-visible row.
//  Ports       : clk, rst_n                   clock, async active-low reset
//                row, col                     timing generator counters
//                wr_req/wr_addr/wr_data       writer request (held until ack)
//                wr_ack                       write issued this cycle
//                mem_addr/mem_we/mem_wdata    RAM command
//                mem_rdata                    RAM data, 1 cycle after a read
//                pix_pop                      display consumes one pixel
//                pix_data/pix_valid           FIFO head / not empty
//                underflow                    sticky: pop while empty
//  Revision    : 1.0  initial release
// ============================================================================
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          row,
    input  logic [15:0]          col,
    input  logic                 wr_req,
    input  logic [FB_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic                 wr_ack,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 pix_pop,
    output logic [DATA_W-1:0]    pix_data,
    output logic                 pix_valid,
    output logic                 underflow
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]         c_depth     = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]         c_low_wm    = (CNT_W + 1)'(LOW_WM);
    localparam logic [FB_ADDR_W-1:0]   c_fb_size   = FB_ADDR_W'(FB_SIZE);
    localparam logic [15:0]            c_v_visible = 16'(V_VISIBLE);

    fb_state_t            r_state;
    fb_state_t            w_state_next;
    logic [FB_ADDR_W-1:0] r_rd_ptr;
    logic [FB_ADDR_W-1:0] r_last_addr;
    logic [DATA_W-1:0]    r_last_wdata;
    logic                 r_inflight;
    logic                 r_underflow;

    logic [CNT_W-1:0]     w_count;
    logic [CNT_W:0]       w_level;
    logic                 w_eligible;
    logic                 w_urgent;
    logic                 w_grant_rd;
    logic                 w_grant_wr;
    logic                 w_flush;
    logic                 w_push;

    // Occupancy includes the read whose data lands this cycle.
    assign w_level    = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_eligible = (w_level < c_depth) && (r_rd_ptr < c_fb_size);
    assign w_urgent   = w_eligible && (w_level < c_low_wm);

    // Next state and grant.
    always_comb begin
        w_state_next = r_state;
        w_grant_rd   = 1'b0;
        w_grant_wr   = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            sRUN: begin
                if ((row == c_v_visible) && (col == 16'd0)) begin
                    w_state_next = sFLUSH;
                end
                if (w_urgent) begin
                    w_grant_rd = 1'b1;
                end else if (wr_req) begin
                    w_grant_wr = 1'b1;
                end else if (w_eligible) begin
                    w_grant_rd = 1'b1;
                end
            end
            sFLUSH: begin
                w_flush      = 1'b1;
                w_grant_wr   = wr_req;
                w_state_next = sRUN;
            end
            default: begin
                w_state_next = sRUN;
            end
        endcase
        // An access overlapping reset assertion must never reach the RAM.
        if (!rst_n) begin
            w_grant_rd = 1'b0;
            w_grant_wr = 1'b0;
        end
    end

    // RAM command; the address and write data hold their last values when idle.
    always_comb begin
        mem_we    = w_grant_wr;
        wr_ack    = w_grant_wr;
        mem_addr  = r_last_addr;
        mem_wdata = r_last_wdata;
        if (w_grant_wr) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (w_grant_rd) begin
            mem_addr  = r_rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= sRUN;
            r_rd_ptr     <= '0;
            r_last_addr  <= '0;
            r_last_wdata <= '0;
            r_inflight   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_addr  <= mem_addr;
            r_last_wdata <= mem_wdata;
            r_inflight   <= w_grant_rd;
            if (w_flush) begin
                r_rd_ptr <= '0;
            end else if (w_grant_rd) begin
                r_rd_ptr <= r_rd_ptr + FB_ADDR_W'(1);
            end
            if (pix_pop && !pix_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Data returning during the flush cycle belongs to the old frame.
    assign w_push = r_inflight && !w_flush;

    vga_pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_flush),
        .push      (w_push),
        .push_data (mem_rdata),
        .pop       (pix_pop),
        .data      (pix_data),
        .count     (w_count)
    );

    assign pix_valid = (w_count != '0);
    assign underflow = r_underflow;

endmodule : vga_fb_arbiter
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_fb_arbiter
//  Description : Directed self-checking bench for vga_fb_arbiter. The RAM is
//                modelled as a read-only pattern (pixel = low address byte
//                XOR 0xC3) with one cycle of read latency; writes are counted.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [15:0]          row;
    logic [15:0]          col;
    logic                 wr_req;
    logic [FB_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 wr_ack;
    logic [FB_ADDR_W-1:0] mem_addr;
    logic                 mem_we;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata = '0;
    logic                 pix_pop;
    logic [DATA_W-1:0]    pix_data;
    logic                 pix_valid;
    logic                 underflow;

    int n_checks  = 0;
    int n_errors  = 0;
    int wr_seen   = 0;
    int seq_bad   = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .FIFO_DEPTH (16),
        .LOW_WM     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_pop   (pix_pop),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .underflow (underflow)
    );

    function automatic logic [7:0] pix_of(input logic [15:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    // RAM model: registered read of the pattern, count of issued writes.
    always @(posedge clk) begin
        mem_rdata <= pix_of(mem_addr);
        if (mem_we) wr_seen <= wr_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0; row = 16'd0; col = 16'd5;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; pix_pop = 1'b0;

        // ---- reset state, with a write request that must be dropped ----
        repeat (2) @(posedge clk);
        #1;
        wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 8'hA5;
        #1;
        check("rst_we",    32'(mem_we),    0);
        check("rst_ack",   32'(wr_ack),    0);
        check("rst_addr",  32'(mem_addr),  0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_valid", 32'(pix_valid), 0);
        check("rst_pdata", 32'(pix_data),  0);
        check("rst_unf",   32'(underflow), 0);
        tick();
        check("rst_nowrite", 32'(wr_seen), 0);
        wr_req = 1'b0;
        rst_n  = 1'b1;

        // ---- prefetch fill: reads 0..15 on consecutive cycles ----
        for (int i = 0; i < 16; i++) begin
            #1;
            check("fill_addr", 32'(mem_addr), 32'(i));
            check("fill_we",   32'(mem_we),   0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            #1;
            check("full_hold_addr", 32'(mem_addr), 15);
            tick();
        end
        #1;
        check("full_valid", 32'(pix_valid), 1);
        check("full_head",  32'(pix_data),  32'(pix_of(16'd0)));

        // ---- write with FIFO full ----
        tick();
        wr_req = 1'b1; wr_addr = 16'h0100; wr_data = 8'hA5;
        #1;
        check("wr_we",    32'(mem_we),    1);
        check("wr_addr",  32'(mem_addr),  32'h0100);
        check("wr_wdata", 32'(mem_wdata), 32'hA5);
        check("wr_ack",   32'(wr_ack),    1);
        tick();
        wr_req = 1'b0;
        #1;
        check("wr_ack_pulse", 32'(wr_ack),   0);
        check("wr_idle_we",   32'(mem_we),   0);
        check("wr_idle_addr", 32'(mem_addr), 32'h0100);
        check("wr_fifo_head", 32'(pix_data), 32'(pix_of(16'd0)));
        check("wr_count",     32'(wr_seen),  1);

        // ---- drain to level 7 while writes win, then urgent read ----
        tick();
        wr_req = 1'b1; wr_addr = 16'h0200; wr_data = 8'h5A; pix_pop = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            check("drain_ack", 32'(wr_ack),   1);
            check("drain_pix", 32'(pix_data), 32'(pix_of(16'(k))));
            tick();
        end
        pix_pop = 1'b0;
        #1;
        check("urg_ack",  32'(wr_ack),   0);
        check("urg_we",   32'(mem_we),   0);
        check("urg_addr", 32'(mem_addr), 16);
        tick();
        #1;
        check("wm_ack",  32'(wr_ack),   1);
        check("wm_addr", 32'(mem_addr), 32'h0200);

        // ---- frame restart with a read in flight ----
        tick();
        wr_req = 1'b0; row = 16'd480; col = 16'd0;
        #1;
        check("pre_flush_addr", 32'(mem_addr), 17);
        tick();
        row = 16'd0; col = 16'd1;
        wr_req = 1'b1; wr_addr = 16'h0300; wr_data = 8'h77;
        #1;
        check("flush_ack",  32'(wr_ack),   1);
        check("flush_addr", 32'(mem_addr), 32'h0300);
        tick();
        wr_req = 1'b0;
        #1;
        check("post_flush_valid", 32'(pix_valid), 0);
        check("post_flush_addr",  32'(mem_addr),  0);
        tick();
        #1;
        check("post_flush_addr1", 32'(mem_addr), 1);
        tick();
        #1;
        check("post_flush_valid2", 32'(pix_valid), 1);
        check("post_flush_head",   32'(pix_data),  32'(pix_of(16'd0)));
        check("no_underflow",      32'(underflow), 0);

        // ---- reset again; pop every cycle from the first cycle ----
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(pix_valid), 0);
        tick();
        tick();
        rst_n = 1'b1; pix_pop = 1'b1;
        #1;
        check("pop0_unf", 32'(underflow), 0);
        tick();
        #1;
        check("pop1_unf",   32'(underflow), 1);
        check("pop1_valid", 32'(pix_valid), 0);
        for (int k = 2; k < 23046; k++) begin
            tick();
            #1;
            if (k <= 23041) begin
                if (k < 10) begin
                    check("stream_valid", 32'(pix_valid), 1);
                    check("stream_pix",   32'(pix_data),  32'(pix_of(16'(k - 2))));
                end else if (!pix_valid || pix_data !== pix_of(16'(k - 2))) begin
                    seq_bad++;
                end
            end
            if (k == 23039) check("last_read_addr", 32'(mem_addr), 23039);
            if (k >= 23040 && k <= 23043) begin
                check("sat_addr", 32'(mem_addr), 23039);
                check("sat_we",   32'(mem_we),   0);
            end
            if (k == 23042) check("end_valid", 32'(pix_valid), 0);
        end
        check("stream_gaps", 32'(seq_bad), 0);

        // ---- writes after the frame is fully fetched ----
        pix_pop = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            wr_req = 1'b1; wr_addr = 16'hF000 + 16'(j); wr_data = 8'(j);
            #1;
            check("sat_wr_ack",  32'(wr_ack),   1);
            check("sat_wr_addr", 32'(mem_addr), 32'hF000 + 32'(j));
        end
        tick();
        wr_req = 1'b0;
        #1;
        check("wr_total", 32'(wr_seen), 16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vga_fb_arbiter
`default_nettype wire
